gate_truth_sweeper: RTL and testbench

//  Self-sequencing truth-table engine for an N_IN-input gate with a selectable function.
//  On start, sweeps every input combination, one per clock, and evaluates the gate on each.

---
 rtl/gate_truth_sweeper.sv | 123 ++++++++++++
 tb/tb_gate_truth_sweeper.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_sweeper.sv
// Truth-table engine: after a start, applies every input combination of an
// N_IN-input gate, one per clock, and collects the gate outputs into a bitmap.
module gate_truth_sweeper #(
    parameter int N_IN = 2,
    localparam int TT_W = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      mode,
    output logic            busy,
    output logic [N_IN-1:0] a_vec,
    output logic            s,
    output logic [TT_W-1:0] table_out,
    output logic            done,
    output logic            err,
    output logic [1:0]      dbg_state_o
);

    // Handshake: start is a request taken on a rising edge only while busy is low;
    // while busy is high it is ignored (no back-pressure, nothing is queued).

    localparam logic [2:0] MODE_AND  = 3'd0;
    localparam logic [2:0] MODE_OR   = 3'd1;
    localparam logic [2:0] MODE_NAND = 3'd2;
    localparam logic [2:0] MODE_NOR  = 3'd3;
    localparam logic [2:0] MODE_XOR  = 3'd4;
    localparam logic [2:0] MODE_XNOR = 3'd5;

    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [2:0]      mode_q, mode_d;
    logic [TT_W-1:0] table_q, table_d;
    logic            err_q, err_d;
    logic            gate_now;
    logic            mode_legal;

    function automatic logic gate_eval(input logic [2:0] m, input logic [N_IN-1:0] v);
        case (m)
            MODE_AND:  return &v;
            MODE_OR:   return |v;
            MODE_NAND: return ~&v;
            MODE_NOR:  return ~|v;
            MODE_XOR:  return ^v;
            MODE_XNOR: return ~^v;
            default:   return 1'b0;
        endcase
    endfunction

    assign gate_now   = gate_eval(mode_q, idx_q);
    assign mode_legal = (mode <= MODE_XNOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= MODE_NOR;
            table_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            table_q <= table_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        table_d = table_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (mode_legal) begin
                        mode_d  = mode;
                        idx_d   = '0;
                        table_d = '0;
                        err_d   = 1'b0;
                        state_d = S_SWEEP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_SWEEP: begin
                table_d[idx_q] = gate_now;
                // The index stops at the last combination instead of wrapping.
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + N_IN'(1);
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gate output is forced low while reset is held so every output reads 0 in reset.
    assign s           = rst_n & gate_now;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign a_vec       = idx_q;
    assign table_out   = table_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// Bench for gate_truth_sweeper: a 2-input and a 3-input instance checked against
// a popcount-based model of each gate function.
module tb_gate_truth_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] mode;
    logic       busy, s, done, err;
    logic [1:0] a_vec;
    logic [3:0] table_out;
    logic [1:0] dbg_state;

    logic       start3;
    logic [2:0] mode3;
    logic       busy3, s3, done3, err3;
    logic [2:0] a_vec3;
    logic [7:0] table3;
    logic [1:0] dbg_state3;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    gate_truth_sweeper #(.N_IN(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy), .a_vec(a_vec), .s(s), .table_out(table_out),
        .done(done), .err(err), .dbg_state_o(dbg_state)
    );

    gate_truth_sweeper #(.N_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode3),
        .busy(busy3), .a_vec(a_vec3), .s(s3), .table_out(table3),
        .done(done3), .err(err3), .dbg_state_o(dbg_state3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: gate output depends only on how many inputs are high
    function automatic bit ref_bit(input int m, input int i, input int n);
        int ones;
        ones = $countones(i);
        case (m)
            0: return ones == n;
            1: return ones > 0;
            2: return ones != n;
            3: return ones == 0;
            4: return (ones % 2) == 1;
            5: return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] ref_table(input int m, input int n);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < (1 << n); i++) t[i] = ref_bit(m, i, n);
        return t;
    endfunction

    // driver: one full sweep on the 2-input instance, checked cycle by cycle
    task automatic sweep2(input logic [2:0] m, input bit noisy, input bit hold, input string tag);
        logic [63:0] et;
        logic [7:0]  e;
        et = ref_table(int'(m), 2);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back({i[6:0], ref_bit(int'(m), i, 2)});
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = hold;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL %s err_clear: err=%b expected 0", tag, err);
        end
        for (int c = 0; c < 4; c++) begin
            e = exp_q.pop_front();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || {5'd0, a_vec, s} !== e) begin
                failures++;
                $display("FAIL %s step%0d: busy=%b done=%b vec_s=%h expected busy=1 done=0 vec_s=%h",
                         tag, c, busy, done, {5'd0, a_vec, s}, e);
            end
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                mode  = 3'($urandom_range(0, 7));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL %s done_pulse: done=%b busy=%b expected 1 1", tag, done, busy);
        end
        checks++;
        if (table_out !== et[3:0]) begin
            failures++;
            $display("FAIL %s table: got %b expected %b", tag, table_out, et[3:0]);
        end
        if (noisy) begin
            start = 1'b1;
            mode  = 3'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || a_vec !== 2'd0) begin
            failures++;
            $display("FAIL %s back_idle: done=%b busy=%b a_vec=%0d expected 0 0 0", tag, done, busy, a_vec);
        end
        if (!hold) start = 1'b0;
        if (noisy) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || table_out !== et[3:0]) begin
                failures++;
                $display("FAIL %s no_restart: busy=%b done=%b table=%b expected 0 0 %b",
                         tag, busy, done, table_out, et[3:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 3'd0;
        start3 = 1'b0;
        mode3  = 3'd0;
        #12;
        checks++;
        if ({busy, a_vec, s, table_out, done, err} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outs2: got %b expected all 0", {busy, a_vec, s, table_out, done, err});
        end
        checks++;
        if ({busy3, a_vec3, s3, table3, done3, err3} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outs3: got %b expected all 0", {busy3, a_vec3, s3, table3, done3, err3});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || a_vec !== 2'd0 || s !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle_nor: busy=%b a_vec=%0d s=%b expected 0 0 1", busy, a_vec, s);
        end
    endtask

    task automatic test_nor();
        sweep2(3'd3, 1'b0, 1'b0, "nor");
        checks++;
        if (table_out !== 4'b0001) begin
            failures++;
            $display("FAIL nor_const: got %b expected 0001", table_out);
        end
    endtask

    task automatic test_back_to_back();
        sweep2(3'd2, 1'b0, 1'b1, "b2b_nand");
        checks++;
        if (table_out !== 4'b0111) begin
            failures++;
            $display("FAIL b2b_nand_const: got %b expected 0111", table_out);
        end
        sweep2(3'd4, 1'b0, 1'b1, "b2b_xor");
        checks++;
        if (table_out !== 4'b0110) begin
            failures++;
            $display("FAIL b2b_xor_const: got %b expected 0110", table_out);
        end
        sweep2(3'd0, 1'b0, 1'b0, "b2b_and");
        checks++;
        if (table_out !== 4'b1000) begin
            failures++;
            $display("FAIL b2b_and_const: got %b expected 1000", table_out);
        end
    endtask

    task automatic run3(input logic [2:0] m, input logic [7:0] want, input string tag);
        logic [63:0] et;
        logic [7:0]  e;
        int busy_n, done_n, done_at;
        et = ref_table(int'(m), 3);
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({i[6:0], ref_bit(int'(m), i, 3)});
        @(negedge clk);
        start3 = 1'b1;
        mode3  = m;
        @(posedge clk); #1;
        start3 = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int c = 1; c <= 14; c++) begin
            if (busy3) busy_n++;
            if (done3) begin
                done_n++;
                done_at = c;
            end
            if (c <= 8) begin
                e = exp_q.pop_front();
                checks++;
                if ({4'd0, a_vec3, s3} !== e) begin
                    failures++;
                    $display("FAIL %s step%0d: vec_s=%h expected %h", tag, c, {4'd0, a_vec3, s3}, e);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (busy_n != 9 || done_n != 1 || done_at != 9) begin
            failures++;
            $display("FAIL %s timing: busy_cycles=%0d done_pulses=%0d done_at=%0d expected 9 1 9",
                     tag, busy_n, done_n, done_at);
        end
        checks++;
        if (table3 !== et[7:0] || table3 !== want) begin
            failures++;
            $display("FAIL %s table: got %h expected %h", tag, table3, want);
        end
    endtask

    task automatic test_n3();
        run3(3'd4, 8'h96, "n3_xor");
        run3(3'd0, 8'h80, "n3_and");
    endtask

    task automatic test_ignore_start();
        for (int k = 0; k < 3; k++) sweep2(3'($urandom_range(0, 5)), 1'b1, 1'b0, "noisy");
    endtask

    task automatic test_async_reset();
        bit hit;
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        mode  = 3'd1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (a_vec == 2'd2 && busy) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL areset_reach_idx2: a_vec=%0d expected 2 within 10 cycles", a_vec);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, a_vec, s, table_out, done, err} !== 9'd0) begin
            failures++;
            $display("FAIL areset_immediate: got %b expected all 0", {busy, a_vec, s, table_out, done, err});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_no_done: done=%b busy=%b expected 0 0", done, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sweep2(3'd1, 1'b0, 1'b0, "after_reset_or");
    endtask

    task automatic test_illegal();
        logic [63:0] prior;
        sweep2(3'd5, 1'b0, 1'b0, "pre_xnor");
        prior = ref_table(5, 2);
        @(negedge clk);
        start = 1'b1;
        mode  = 3'($urandom_range(6, 7));
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || table_out !== prior[3:0]) begin
            failures++;
            $display("FAIL illegal_mode: err=%b busy=%b table=%b expected 1 0 %b", err, busy, table_out, prior[3:0]);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || s !== ref_bit(5, 0, 2)) begin
            failures++;
            $display("FAIL illegal_sticky: err=%b busy=%b s=%b expected 1 0 %b", err, busy, s, ref_bit(5, 0, 2));
        end
        sweep2(3'd1, 1'b0, 1'b0, "post_illegal_or");
        checks++;
        if (table_out !== 4'b1110 || err !== 1'b0) begin
            failures++;
            $display("FAIL or_const: table=%b err=%b expected 1110 0", table_out, err);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            sweep2(3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_nor();
        test_back_to_back();
        test_n3();
        test_ignore_start();
        test_async_reset();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
